// File: rtl/sdc_tx_block_packer.sv
// SD data transmit block packer: turns a 32-bit word stream into the
// transmitter's 8-bit valid/ready/last byte stream, one SD block at a time.
// Counts blocks for single- and multi-block writes and pulses done at the end.
// Optional feature macro: SDC_PACKER_ABORT_EN adds abort/aborted; once aborted,
// the rest of the current block is padded with 8'hFF.
module sdc_tx_block_packer #(
    parameter int unsigned BLOCK_BYTES   = 512,
    parameter int unsigned CNT_W         = 16,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] blockCount,
    input  logic [31:0]      w_data,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blocksLeft,
    output logic             done
`ifdef SDC_PACKER_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int unsigned BC_W = $clog2(BLOCK_BYTES);
    localparam logic [BC_W-1:0] LAST_CNT = BC_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_buf;
    logic             r_full;
    logic [1:0]       r_idx;
    logic [BC_W-1:0]  r_cnt;
    logic [CNT_W-1:0] r_left;

    logic             w_pad;
    logic             w_abort_req;
    logic             w_byte_acc;
    logic             w_block_end;
    logic             w_final;
    logic             w_word_acc;
    logic [1:0]       w_sel;

`ifdef SDC_PACKER_ABORT_EN
    logic r_pad;
    logic r_aborted;

    assign w_pad       = r_pad;
    assign w_abort_req = abort && (r_state == S_RUN);
    assign aborted     = r_aborted;

    // Pad flag lives from abort until the padded block's last byte leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_pad     <= (r_state == S_RUN) && (r_pad || abort) && !w_final;
            r_aborted <= r_pad && w_final;
        end
    end
`else
    assign w_pad       = 1'b0;
    assign w_abort_req = 1'b0;
`endif

    // Byte-side handshake and block/transfer boundary detection.
    always_comb begin
        out_valid   = r_full || w_pad;
        out_last    = out_valid && (r_cnt == LAST_CNT);
        w_byte_acc  = out_valid && out_ready;
        w_block_end = w_byte_acc && out_last;
        // An aborted transfer ends at the padded block's last byte.
        w_final     = w_block_end && ((r_left == CNT_W'(1)) || w_pad);
        w_sel       = LITTLE_ENDIAN ? r_idx : ~r_idx;
        out_data    = w_pad ? 8'hFF : r_buf[{w_sel, 3'b000} +: 8];
        // Refill allowed in the same cycle the buffer's last byte drains.
        w_ready     = (r_state == S_RUN) && !w_pad && !w_abort_req && !w_final &&
                      (!r_full || (w_byte_acc && (r_idx == 2'd3)));
        w_word_acc  = w_valid && w_ready;
        blocksLeft  = r_left;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_next = (blockCount != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (w_final) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Word buffer, byte index, in-block byte counter and remaining-block count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_full <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_left <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_left <= blockCount;
            else if (w_block_end)           r_left <= r_left - CNT_W'(1);

            if (w_byte_acc) r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + BC_W'(1);

            if (w_word_acc) begin
                r_buf  <= w_data;
                r_full <= 1'b1;
            end else if (w_abort_req || (w_byte_acc && !w_pad && r_idx == 2'd3)) begin
                r_full <= 1'b0;
            end

            // Buffered data is dropped on abort, so the index restarts at 0.
            if (w_abort_req)                r_idx <= '0;
            else if (w_byte_acc && !w_pad)  r_idx <= r_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_sdc_tx_block_packer.sv
// Self-checking bench for sdc_tx_block_packer (BLOCK_BYTES=8, little endian).
// Table of transfer scenarios run through a byte scoreboard, plus hand-written
// reset-mid-block and (with SDC_PACKER_ABORT_EN) abort sequences.
module tb_sdc_tx_block_packer;

    localparam int BB   = 8;
    localparam int CW   = 16;
    localparam int MAXC = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] blockCount;
    logic [31:0]   w_data;
    logic          w_valid;
    logic          w_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] blocksLeft;
    logic          done;
`ifdef SDC_PACKER_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    sdc_tx_block_packer #(
        .BLOCK_BYTES  (BB),
        .CNT_W        (CW),
        .LITTLE_ENDIAN(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .blockCount(blockCount),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .blocksLeft(blocksLeft),
        .done      (done)
`ifdef SDC_PACKER_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int nblk;
        int rdy_pct;
        int val_pct;
        bit poke_start;
        int exp_bytes;
        int exp_lasts;
        int exp_words;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] wq[$];
    logic [7:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        int       wi, bytes, lasts, words, first_step, last_step;
        bit       exp_done, nxt_done, finished, poked, prev_stall, prev_last;
        logic [7:0] prev_data, eb;
        wq = {};
        exp_q = {};
        // One spare word beyond the transfer so a stray extra accept is visible.
        for (int i = 0; i < v.nblk * BB / 4 + 1; i++) begin
            if (i == 0)      wq.push_back(32'h4433_2211);
            else if (i == 1) wq.push_back(32'h8877_6655);
            else             wq.push_back($urandom);
        end
        wi = 0; bytes = 0; lasts = 0; words = 0; first_step = -1; last_step = -1;
        exp_done = 0; finished = 0; poked = 0; prev_stall = 0; prev_last = 0;
        prev_data = '0;
        for (int cyc = 0; cyc < MAXC && !finished; cyc++) begin
            out_ready = ($urandom_range(99) < v.rdy_pct);
            w_valid   = (wi < wq.size()) && ($urandom_range(99) < v.val_pct);
            w_data    = (wi < wq.size()) ? wq[wi] : 32'h0;
            start     = 1'b0;
            if (cyc == 0) begin
                start      = 1'b1;
                blockCount = CW'(v.nblk);
            end else if (v.poke_start && !poked && bytes == 5) begin
                start      = 1'b1;
                blockCount = CW'(9);
                poked      = 1;
            end
            @(negedge clk);
            check("done", done, exp_done);
            check("busy", busy, cyc > 0);
            check("blocksLeft", blocksLeft, (cyc > 0) ? v.nblk - lasts : 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            nxt_done = (cyc == 0 && v.nblk == 0);
            if (w_valid && w_ready) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(wq[wi][b*8 +: 8]);
                wi++;
                words++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", out_data, 8'h00);
                    n_fail++;
                    $display("FAIL sb_underflow: got byte 0x%0h, expected no byte", out_data);
                end else begin
                    eb = exp_q.pop_front();
                    check("byte", out_data, eb);
                end
                check("last", out_last, (bytes % BB) == BB - 1);
                if (first_step < 0) first_step = cyc;
                last_step = cyc;
                bytes++;
                if (out_last) begin
                    lasts++;
                    if (lasts == v.nblk) nxt_done = 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (exp_done) finished = 1;
            exp_done = nxt_done;
            tick();
        end
        start   = 1'b0;
        w_valid = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done within %0d cycles, expected done", MAXC);
        end
        check("n_bytes", bytes, v.exp_bytes);
        check("n_lasts", lasts, v.exp_lasts);
        check("n_words", words, v.exp_words);
        check("sb_left", exp_q.size(), 0);
        if (v.rdy_pct == 100 && v.val_pct == 100 && v.nblk > 0)
            check("throughput", last_step - first_step + 1, v.exp_bytes);
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_wready", w_ready, 0);
        tick();
    endtask

    initial begin : main
        int nacc;
        vecs[0] = '{nblk: 1, rdy_pct: 100, val_pct: 100, poke_start: 0,
                    exp_bytes: 8,  exp_lasts: 1, exp_words: 2};
        vecs[1] = '{nblk: 3, rdy_pct: 100, val_pct: 100, poke_start: 0,
                    exp_bytes: 24, exp_lasts: 3, exp_words: 6};
        vecs[2] = '{nblk: 2, rdy_pct: 50,  val_pct: 60,  poke_start: 1,
                    exp_bytes: 16, exp_lasts: 2, exp_words: 4};
        vecs[3] = '{nblk: 4, rdy_pct: 30,  val_pct: 40,  poke_start: 0,
                    exp_bytes: 32, exp_lasts: 4, exp_words: 8};
        vecs[4] = '{nblk: 0, rdy_pct: 100, val_pct: 100, poke_start: 0,
                    exp_bytes: 0,  exp_lasts: 0, exp_words: 0};

        rst = 1'b1; start = 1'b0; blockCount = '0; w_data = '0; w_valid = 1'b0;
        out_ready = 1'b0;
`ifdef SDC_PACKER_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_out_last", out_last, 0);
        check("rst_blocksLeft", blocksLeft, 0);
        tick();
        rst = 1'b0;

        for (int t = 0; t < 5; t++) run_xfer(vecs[t]);

        // Reset after three bytes of a block have been accepted.
        start = 1'b1; blockCount = CW'(1); w_valid = 1'b1; w_data = 32'hDEAD_BEEF;
        out_ready = 1'b1; nacc = 0;
        for (int c = 0; c < 50 && nacc < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) nacc++;
            tick();
            start = 1'b0;
        end
        check("rst_prep_bytes", nacc, 3);
        rst = 1'b1; w_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_blocksLeft", blocksLeft, 0);
        check("midrst_w_ready", w_ready, 0);
        tick();
        run_xfer(vecs[0]);

`ifdef SDC_PACKER_ABORT_EN
        begin : abort_seq
            logic [7:0] got[8];
            int wi, nb, idx_last;
            bit seen_done;
            start = 1'b1; blockCount = CW'(1); out_ready = 1'b1; w_valid = 1'b1;
            wi = 0; nb = 0; idx_last = -1; seen_done = 0;
            for (int c = 0; c < 50 && nb < 3; c++) begin
                w_data = (wi == 0) ? 32'h4433_2211 : 32'h8877_6655;
                @(negedge clk);
                if (w_valid && w_ready) wi++;
                if (out_valid && out_ready) begin
                    got[nb] = out_data;
                    nb++;
                end
                tick();
                start = 1'b0;
            end
            abort = 1'b1; out_ready = 1'b0;
            tick();
            abort = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 50 && !seen_done; c++) begin
                @(negedge clk);
                if (done) begin
                    seen_done = 1;
                    check("abort_aborted", aborted, 1);
                end else begin
                    check("abort_pad_wready", w_ready, 0);
                    check("abort_flag_early", aborted, 0);
                    if (out_valid && out_ready && nb < 8) begin
                        got[nb] = out_data;
                        if (out_last) idx_last = nb;
                        nb++;
                    end
                end
                tick();
            end
            w_valid = 1'b0;
            check("abort_done_seen", seen_done, 1);
            check("abort_nbytes", nb, 8);
            check("abort_last_idx", idx_last, 7);
            check("abort_b0", got[0], 8'h11);
            check("abort_b1", got[1], 8'h22);
            check("abort_b2", got[2], 8'h33);
            for (int k = 3; k < 8; k++) check("abort_pad", got[k], 8'hFF);
            @(negedge clk);
            check("abort_post_busy", busy, 0);
            check("abort_post_aborted", aborted, 0);
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
